// File: rtl/cnn_frame_scheduler_if.sv
// Frame scheduler bus: start request, source stream, pipeline stream
// and status. master = frame driver side, slave = scheduler side.
// Optional perf counters appear with SCHED_PERF_CNT_EN.
interface cnn_frame_scheduler_if;
  logic               start;
  logic signed [15:0] src_pixel;
  logic               src_valid;
  logic               src_ready;
  logic signed [15:0] pipe_pixel;
  logic               pipe_valid;
  logic               pipe_ready;
  logic [3:0]         pipe_vout;
  logic               busy;
  logic               done;
  logic               timeout_err;
  logic [15:0]        frame_cnt;
  logic [9:0]         in_cnt;
  logic [9:0]         out_cnt;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0]        stall_cnt;
  logic [15:0]        latency_cnt;

  modport master (
    output start, src_pixel, src_valid,
    output pipe_ready, pipe_vout,
    input  src_ready, pipe_pixel, pipe_valid,
    input  busy, done, timeout_err,
    input  frame_cnt, in_cnt, out_cnt,
    input  stall_cnt, latency_cnt
  );

  modport slave (
    input  start, src_pixel, src_valid,
    input  pipe_ready, pipe_vout,
    output src_ready, pipe_pixel, pipe_valid,
    output busy, done, timeout_err,
    output frame_cnt, in_cnt, out_cnt,
    output stall_cnt, latency_cnt
  );
`else
  modport master (
    output start, src_pixel, src_valid,
    output pipe_ready, pipe_vout,
    input  src_ready, pipe_pixel, pipe_valid,
    input  busy, done, timeout_err,
    input  frame_cnt, in_cnt, out_cnt
  );

  modport slave (
    input  start, src_pixel, src_valid,
    input  pipe_ready, pipe_vout,
    output src_ready, pipe_pixel, pipe_valid,
    output busy, done, timeout_err,
    output frame_cnt, in_cnt, out_cnt
  );
`endif
endinterface

// File: rtl/cnn_frame_scheduler.sv
// Frame-level controller for the conv pipeline: feeds one frame per
// start, counts result beats on pipe_vout[0], raises done/timeout.
// Ports: clk, reset (sync, active-low), sif (slave modport).
// Option: SCHED_PERF_CNT_EN adds stall_cnt / latency_cnt.
module cnn_frame_scheduler #(
  parameter int IMG_W         = 28,
  parameter int IMG_H         = 28,
  parameter int OUT_PIX       = 484,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input logic                 clk,
  input logic                 reset,
  cnn_frame_scheduler_if.slave sif
);

  localparam int IN_PIX = IMG_W * IMG_H;
  localparam int TW     = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [9:0] IN_LAST = 10'(IN_PIX - 1);
  localparam logic [9:0] OUT_MAX = 10'(OUT_PIX);
  localparam logic [TW-1:0] TO_LAST =
    TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic               busy;
  logic               done;
  logic               timeout_err;
  logic [15:0]        frame_cnt;
  logic [9:0]         in_cnt;
  logic [9:0]         out_cnt;
  logic [TW-1:0]      tcnt;
  logic signed [15:0] last_pix;

  logic feed;
  logic xfer;
  logic beat;
  logic out_full;
  logic unused_vout;

  assign feed     = (state == S_FEED);
  assign xfer     = feed && sif.src_valid && sif.pipe_ready;
  assign beat     = sif.pipe_vout[0];
  assign out_full = (out_cnt == OUT_MAX);

  assign unused_vout = ^sif.pipe_vout[3:1];

  // Zero-latency pass-through while feeding; otherwise the
  // pipeline sees the last accepted pixel with valid low.
  assign sif.src_ready  = feed && sif.pipe_ready;
  assign sif.pipe_valid = feed && sif.src_valid;
  assign sif.pipe_pixel = feed ? sif.src_pixel : last_pix;

  assign sif.busy        = busy;
  assign sif.done        = done;
  assign sif.timeout_err = timeout_err;
  assign sif.frame_cnt   = frame_cnt;
  assign sif.in_cnt      = in_cnt;
  assign sif.out_cnt     = out_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= 16'd0;
      in_cnt      <= 10'd0;
      out_cnt     <= 10'd0;
      tcnt        <= '0;
      last_pix    <= 16'sd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sif.start) begin
            state       <= S_FEED;
            busy        <= 1'b1;
            in_cnt      <= 10'd0;
            out_cnt     <= 10'd0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_FEED: begin
          if (beat && !out_full)
            out_cnt <= out_cnt + 10'd1;
          if (xfer) begin
            in_cnt   <= in_cnt + 10'd1;
            last_pix <= sif.src_pixel;
            if (in_cnt == IN_LAST) begin
              // All outputs already seen during feed:
              // nothing left to drain.
              if (out_full) begin
                state     <= S_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
              end else begin
                state <= S_DRAIN;
                tcnt  <= '0;
              end
            end
          end
        end
        S_DRAIN: begin
          if (beat && !out_full)
            out_cnt <= out_cnt + 10'd1;
          if (out_full) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end else if (beat) begin
            tcnt <= '0;
          end else if (tcnt == TO_LAST) begin
            // This idle cycle completes the allowed
            // silence window.
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] latency_cnt;

  assign sif.stall_cnt   = stall_cnt;
  assign sif.latency_cnt = latency_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt   <= 16'd0;
      latency_cnt <= 16'd0;
    end else if (state == S_IDLE) begin
      if (sif.start) begin
        stall_cnt   <= 16'd0;
        latency_cnt <= 16'd0;
      end
    end else if (state != S_DONE) begin
      if (feed && sif.src_valid && !sif.pipe_ready &&
          stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (latency_cnt != 16'hFFFF)
        latency_cnt <= latency_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Directed bench for cnn_frame_scheduler (28x28 frame, 16-cycle
// drain timeout): nominal, backpressure, timeout, reset, early beats.
module tb_cnn_frame_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  cnn_frame_scheduler_if sif ();

  cnn_frame_scheduler #(
    .IMG_W        (28),
    .IMG_H        (28),
    .OUT_PIX      (484),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sif  (sif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_src_ready"}, 32'(sif.src_ready), 0);
    chk({tag, "_pipe_valid"}, 32'(sif.pipe_valid), 0);
    chk({tag, "_pipe_pixel"}, 32'(sif.pipe_pixel), 0);
    chk({tag, "_busy"}, 32'(sif.busy), 0);
    chk({tag, "_done"}, 32'(sif.done), 0);
    chk({tag, "_timeout_err"}, 32'(sif.timeout_err), 0);
    chk({tag, "_frame_cnt"}, 32'(sif.frame_cnt), 0);
    chk({tag, "_in_cnt"}, 32'(sif.in_cnt), 0);
    chk({tag, "_out_cnt"}, 32'(sif.out_cnt), 0);
  endtask

  initial begin
    logic signed [15:0] px;
    int xf;
    int st;
    int first;

    sif.start      = 1'b0;
    sif.src_valid  = 1'b0;
    sif.src_pixel  = 16'sd0;
    sif.pipe_ready = 1'b0;
    sif.pipe_vout  = 4'b0000;

    // Reset state
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();

    // Nominal frame
    start_frame();
    chk("nom_busy", 32'(sif.busy), 1);
    px = 16'sd0;
    for (int i = 0; i < 784; i++) begin
      px = 16'(i * 3 - 500);
      sif.src_valid  = 1'b1;
      sif.src_pixel  = px;
      sif.pipe_ready = 1'b1;
      #1;
      if (i == 0 || i == 783) begin
        chk("nom_src_ready", 32'(sif.src_ready), 1);
        chk("nom_pipe_valid", 32'(sif.pipe_valid), 1);
      end
      chk("nom_pix", 32'(sif.pipe_pixel), 32'(px));
      tick();
    end
    sif.src_valid = 1'b0;
    sif.src_pixel = 16'sh7777;
    #1;
    chk("nom_in_cnt", 32'(sif.in_cnt), 784);
    chk("nom_drain_busy", 32'(sif.busy), 1);
    chk("nom_drain_src_ready", 32'(sif.src_ready), 0);
    chk("nom_drain_pipe_valid", 32'(sif.pipe_valid), 0);
    chk("nom_hold_pix", 32'(sif.pipe_pixel), 32'(16'sd1849));
    for (int j = 0; j < 484; j++) begin
      sif.pipe_vout = 4'b0001;
      tick();
    end
    sif.pipe_vout = 4'b1110;
    chk("nom_out_cnt", 32'(sif.out_cnt), 484);
    chk("nom_done_early", 32'(sif.done), 0);
    chk("nom_busy_t1", 32'(sif.busy), 1);
    tick();
    chk("nom_done", 32'(sif.done), 1);
    chk("nom_frame_cnt", 32'(sif.frame_cnt), 1);
    chk("nom_busy_done", 32'(sif.busy), 0);
    chk("nom_timeout_err", 32'(sif.timeout_err), 0);
    tick();
    chk("nom_done_pulse", 32'(sif.done), 0);

    // Backpressure, start ignored in FEED/DRAIN/DONE
    start_frame();
    xf = 0;
    st = 0;
    for (int c = 0; c < 3000 && xf < 784; c++) begin
      px = 16'(xf + 1000);
      sif.src_valid  = 1'b1;
      sif.src_pixel  = px;
      sif.pipe_ready = (c % 2 == 0);
      sif.start      = (c == 10);
      sif.pipe_vout  = 4'b1110;
      #1;
      chk("bp_in_cnt", 32'(sif.in_cnt), 32'(xf));
      chk("bp_pix", 32'(sif.pipe_pixel), 32'(px));
      chk("bp_src_ready", 32'(sif.src_ready),
          32'(sif.pipe_ready));
      if (sif.pipe_ready) xf++;
      else st++;
      tick();
    end
    sif.start     = 1'b0;
    sif.src_valid = 1'b0;
    chk("bp_in_total", 32'(sif.in_cnt), 784);
`ifdef SCHED_PERF_CNT_EN
    chk("bp_stall_cnt", 32'(sif.stall_cnt), 783);
`endif
    for (int j = 0; j < 484; j++) begin
      if (j > 0) begin
        sif.pipe_vout = 4'b1110;
        tick();
      end
      sif.pipe_vout = 4'b0001;
      sif.start     = (j == 5);
      tick();
    end
    sif.pipe_vout = 4'b0000;
    sif.start     = 1'b1;
    chk("bp_out_cnt", 32'(sif.out_cnt), 484);
    chk("bp_busy_t1", 32'(sif.busy), 1);
    tick();
    chk("bp_done", 32'(sif.done), 1);
    chk("bp_frame_cnt", 32'(sif.frame_cnt), 2);
`ifdef SCHED_PERF_CNT_EN
    chk("bp_latency_cnt", 32'(sif.latency_cnt), 2535);
`endif
    tick();
    sif.start = 1'b0;
    chk("bp_idle_busy", 32'(sif.busy), 0);
    tick();
    chk("bp_no_restart", 32'(sif.busy), 0);
    chk("bp_frame_once", 32'(sif.frame_cnt), 2);

    // Drain timeout after 100 beats
    start_frame();
    for (int i = 0; i < 784; i++) begin
      sif.src_valid  = 1'b1;
      sif.src_pixel  = 16'(i);
      sif.pipe_ready = 1'b1;
      sif.pipe_vout  = 4'b1110;
      tick();
    end
    sif.src_valid = 1'b0;
    for (int j = 0; j < 100; j++) begin
      sif.pipe_vout = 4'b0001;
      tick();
    end
    sif.pipe_vout = 4'b1110;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      if (sif.done === 1'b1) first = k;
      else tick();
    end
    chk("to_done_delay_in_window",
        32'(first >= 16 && first <= 17), 1);
    chk("to_err", 32'(sif.timeout_err), 1);
    chk("to_frame_cnt", 32'(sif.frame_cnt), 3);
    chk("to_out_cnt", 32'(sif.out_cnt), 100);
    tick();
    chk("to_done_pulse", 32'(sif.done), 0);
    chk("to_err_sticky", 32'(sif.timeout_err), 1);
    chk("to_idle_busy", 32'(sif.busy), 0);
    start_frame();
    chk("to_err_clr", 32'(sif.timeout_err), 0);
    chk("to_in_clr", 32'(sif.in_cnt), 0);
    chk("to_out_clr", 32'(sif.out_cnt), 0);

    // Reset mid-frame
    for (int i = 0; i < 300; i++) begin
      sif.src_valid  = 1'b1;
      sif.src_pixel  = 16'(i + 7);
      sif.pipe_ready = 1'b1;
      tick();
    end
    chk("mid_in_cnt", 32'(sif.in_cnt), 300);
    reset = 1'b0;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b1;
    tick();
    chk("mid_stay_idle", 32'(sif.busy), 0);

    // Frame with all beats during FEED: FEED -> DONE
    start_frame();
    for (int i = 0; i < 784; i++) begin
      sif.src_valid  = 1'b1;
      sif.src_pixel  = 16'(-i);
      sif.pipe_ready = 1'b1;
      sif.pipe_vout  = 4'b0001;
      tick();
    end
    sif.src_valid = 1'b0;
    chk("early_done", 32'(sif.done), 1);
    chk("early_out_sat", 32'(sif.out_cnt), 484);
    chk("early_in_cnt", 32'(sif.in_cnt), 784);
    chk("early_frame_cnt", 32'(sif.frame_cnt), 1);
    chk("early_busy", 32'(sif.busy), 0);
    tick();
    chk("early_done_pulse", 32'(sif.done), 0);
    chk("early_idle_beats", 32'(sif.out_cnt), 484);
    sif.pipe_vout = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cnn_frame_scheduler.md
# cnn_frame_scheduler

Frame-level controller for the three-layer conv pipeline. Gates a raw pixel stream into the pipeline's `pixel_in`/`valid_in`/`ready` port for exactly one frame per `start`, then counts the result beats on `valid_out[0]` until the frame is fully drained. Raises `done` or a timeout error, keeps frame statistics, and holds off the next frame until the current one has drained.

## Interface
- `IMG_W`, 28: input frame width in pixels.
- `IMG_H`, 28: input frame height in pixels.
- `OUT_PIX`, 484: expected output beats per frame, i.e. (IMG_W-6)*(IMG_H-6).
- `DRAIN_TIMEOUT`, 4096: maximum idle cycles in DRAIN with no output beat.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to process one frame; ignored unless in IDLE.
- `src_pixel`  in  16 signed  pixel from the upstream source.
- `src_valid`  in  1  `src_pixel` is valid.
- `src_ready`  out  1  scheduler accepts `src_pixel` this cycle.
- `pipe_pixel`  out  16 signed  drives pipeline `pixel_in`.
- `pipe_valid`  out  1  drives pipeline `valid_in`.
- `pipe_ready`  in  1  pipeline `ready`.
- `pipe_vout`  in  4  pipeline `valid_out`; only bit 0 is counted.
- `busy`  out  1  high in FEED and DRAIN.
- `done`  out  1  one-cycle pulse when a frame completes.
- `timeout_err`  out  1  sticky; set on drain timeout; cleared by reset or by the next accepted `start`.
- `frame_cnt`  out  16  completed frames; wraps at 65535 to 0.
- `in_cnt`  out  10  pixels accepted in the current frame.
- `out_cnt`  out  10  output beats counted in the current frame.

## Operation
- State machine with four states: IDLE, FEED, DRAIN, DONE.
- IDLE -> FEED on `start`. The transition clears `in_cnt`, `out_cnt`, the timeout counter and `timeout_err`.
- In FEED:
  - `src_ready` = `pipe_ready`.
  - `pipe_valid` = `src_valid`.
  - `pipe_pixel` = `src_pixel`. This path is combinational, with zero-cycle pass-through.
  - A transfer occurs when `src_valid && pipe_ready`, and increments `in_cnt`.
- FEED -> DRAIN on the transfer that makes `in_cnt` reach IMG_W*IMG_H.
- Outside FEED:
  - `src_ready`=0 and `pipe_valid`=0.
  - `pipe_pixel` holds the last accepted value.
- Output counting:
  - `out_cnt` increments on every cycle with `pipe_vout[0]`=1 in FEED or DRAIN. Early outputs during FEED are legal.
  - `out_cnt` saturates at OUT_PIX.
  - Beats seen in IDLE or DONE are ignored.
- DRAIN -> DONE when `out_cnt` reaches OUT_PIX. Counting is in the same cycle as the last beat; the transition is registered.
- If FEED completes with `out_cnt` already equal to OUT_PIX, go FEED -> DONE directly.
- Drain timeout:
  - The timeout counter resets on every output beat and increments otherwise in DRAIN.
  - When it reaches DRAIN_TIMEOUT: set `timeout_err` and go to DONE.
- DONE lasts exactly one cycle and then returns to IDLE. On entry to DONE:
  - `done`=1 for that cycle.
  - `frame_cnt` increments, including on timeout.
- `start` while busy or in DONE is dropped and not queued.
- Reset mid-frame forces IDLE and clears every counter and flag. Partial pipeline contents are the user's concern.

## Timing
- Reset values: `src_ready`=0, `pipe_valid`=0, `pipe_pixel`=0, `busy`=0, `done`=0, `timeout_err`=0, `frame_cnt`=0, `in_cnt`=0, `out_cnt`=0; state is IDLE.
- `start` sampled at cycle t -> FEED at t+1, so `src_ready` can be first high at t+1.
- Last input transfer at t -> DRAIN at t+1.
- Final output beat at t -> `out_cnt`=OUT_PIX at t+1 -> `done` at t+2 -> IDLE at t+3.
- `busy` is registered and equals (state==FEED || state==DRAIN).
- All status outputs are registered. Only the three FEED pass-through signals are combinational.

## Configuration
- `SCHED_PERF_CNT_EN` defined:
  - Adds outputs `stall_cnt` (out, 16) and `latency_cnt` (out, 16).
  - `stall_cnt` counts FEED cycles with `src_valid && !pipe_ready`.
  - `latency_cnt` counts cycles from the FEED entry to DONE.
  - Both clear on accepted `start`, saturate at 0xFFFF, and hold their value in IDLE.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

## Test plan
- Nominal frame: `start`, then 784 back-to-back pixels with `pipe_ready`=1, then 484 `pipe_vout[0]` beats. Expect `in_cnt`=784, `done` pulse two cycles after the last beat, `frame_cnt`=1, `timeout_err`=0.
- Backpressure: `pipe_ready` toggles 1/0 each cycle during FEED. Expect exactly 784 transfers, `pipe_pixel` sequence intact with no duplicates, and `stall_cnt`=number of ready-low valid cycles when the macro is defined.
- Timeout with DRAIN_TIMEOUT=16: only 100 output beats, then silence. Expect `timeout_err`=1 and a `done` pulse 16 cycles after the last beat; the next `start` clears `timeout_err`.
- `start` asserted in FEED, in DRAIN and in DONE is ignored: `frame_cnt` increments once and no second frame begins.
- Reset (`reset`=0 for one cycle) at `in_cnt`=300. Expect all outputs at their reset values next cycle, with the state in IDLE. A subsequent full frame completes normally with `frame_cnt`=1.
- Wrap: preload by running 65536 frames with IMG_W=IMG_H=7 and OUT_PIX=1. Expect `frame_cnt` to return to 0.
